// File: rtl/draw_player.sv
// Player sprite overlay: draws a ROM-fetched sprite over the background stream with a 3-cycle
// pipeline. Define DRAW_PLAYER_TRANSPARENT_EN to treat KEY_RGB sprite pixels as see-through.
module draw_player #(
  parameter int unsigned SPR_W    = 48,
  parameter int unsigned SPR_H    = 64,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned XPOS_RST = 100,
  parameter int unsigned YPOS_RST = 436,
  parameter logic [11:0] KEY_RGB  = 12'hF0F
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       vga_hcount_i,
  input  logic [10:0]       vga_vcount_i,
  input  logic              vga_hsync_i,
  input  logic              vga_vsync_i,
  input  logic              vga_hblnk_i,
  input  logic              vga_vblnk_i,
  input  logic [11:0]       vga_rgb_i,
  output logic [10:0]       vga_hcount_o,
  output logic [10:0]       vga_vcount_o,
  output logic              vga_hsync_o,
  output logic              vga_vsync_o,
  output logic              vga_hblnk_o,
  output logic              vga_vblnk_o,
  output logic [11:0]       vga_rgb_o,
  input  logic [10:0]       xpos_i,
  input  logic [10:0]       ypos_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [11:0]       rom_data_i,
  output logic              pos_latched_o
);

`ifdef DRAW_PLAYER_TRANSPARENT_EN
  localparam bit TranspEn = 1'b1;
`else
  localparam bit TranspEn = 1'b0;
`endif

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  vga_t              vga_in, s1_q, s2_q, out_q;
  logic              s1_box_q, s2_box_q;
  logic [10:0]       x_act_q, y_act_q;
  logic              vblnk_prev_q;
  logic              pos_latched_q;
  logic [ADDR_W-1:0] rom_addr_q;

  logic              in_box;
  logic              latch;
  logic [11:0]       h12, v12, x12, y12;
  logic [10:0]       dx, dy;
  logic [ADDR_W-1:0] rom_addr_d;
  logic              opaque;
  logic [11:0]       rgb_d;

  always_comb begin
    vga_in = '{hcount: vga_hcount_i, vcount: vga_vcount_i, hsync: vga_hsync_i,
               vsync: vga_vsync_i, hblnk: vga_hblnk_i, vblnk: vga_vblnk_i, rgb: vga_rgb_i};
    latch  = vga_vblnk_i && !vblnk_prev_q;
    // 12-bit compares so a sprite near the right/bottom edge truncates instead of wrapping
    h12    = {1'b0, vga_hcount_i};
    v12    = {1'b0, vga_vcount_i};
    x12    = {1'b0, x_act_q};
    y12    = {1'b0, y_act_q};
    in_box = !vga_hblnk_i && !vga_vblnk_i &&
             (h12 >= x12) && (h12 < x12 + 12'(SPR_W)) &&
             (v12 >= y12) && (v12 < y12 + 12'(SPR_H));
    dx     = vga_hcount_i - x_act_q;
    dy     = vga_vcount_i - y_act_q;
    rom_addr_d = in_box ? ADDR_W'(32'(dy) * SPR_W + 32'(dx)) : '0;
    opaque = s2_box_q && !(TranspEn && (rom_data_i == KEY_RGB));
    rgb_d  = opaque ? rom_data_i : s2_q.rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      out_q         <= '0;
      s1_box_q      <= 1'b0;
      s2_box_q      <= 1'b0;
      x_act_q       <= 11'(XPOS_RST);
      y_act_q       <= 11'(YPOS_RST);
      vblnk_prev_q  <= 1'b0;
      pos_latched_q <= 1'b0;
      rom_addr_q    <= '0;
    end else begin
      vblnk_prev_q  <= vga_vblnk_i;
      pos_latched_q <= latch;
      if (latch) begin
        x_act_q <= xpos_i;
        y_act_q <= ypos_i;
      end
      s1_q       <= vga_in;
      s1_box_q   <= in_box;
      rom_addr_q <= rom_addr_d;
      s2_q       <= s1_q;
      s2_box_q   <= s1_box_q;
      out_q      <= s2_q;
      out_q.rgb  <= rgb_d;
    end
  end

  assign vga_hcount_o  = out_q.hcount;
  assign vga_vcount_o  = out_q.vcount;
  assign vga_hsync_o   = out_q.hsync;
  assign vga_vsync_o   = out_q.vsync;
  assign vga_hblnk_o   = out_q.hblnk;
  assign vga_vblnk_o   = out_q.vblnk;
  assign vga_rgb_o     = out_q.rgb;
  assign rom_addr_o    = rom_addr_q;
  assign pos_latched_o = pos_latched_q;

endmodule
